// File: rtl/load_store_unit.sv
// Data-side memory stage: lane steering, load extension and a handshaked bus
// request with a bounded wait; the core is stalled until the bus acks or times out.
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int BUS_AW  = 30
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemHalf,
  input  logic              MemByte,
  input  logic              MemSignExtend,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              Stall,
  output logic              AddrErr,
  output logic              BusErr,
  output logic              BusReq,
  output logic              BusWe,
  output logic [BUS_AW-1:0] BusAddr,
  output logic [3:0]        BusBe,
  output logic [31:0]       BusWData,
  input  logic [31:0]       BusRData,
  input  logic              BusAck
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] REQ  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]    state_r;
  logic [CW-1:0] cnt_r;
  logic          ld_rd_r;
  logic          ld_half_r;
  logic          ld_byte_r;
  logic          ld_sext_r;
  logic [1:0]    ld_lo_r;
  logic          acc_s;
  logic          word_s;
  logic          illegal_s;
  logic [29:0]   word_addr_s;

  function automatic logic [3:0] lane_be(input logic half, input logic byt, input logic [1:0] lo);
    logic [3:0] be;
    if (byt)       be = 4'b1000 >> lo;
    else if (half) be = lo[1] ? 4'b0011 : 4'b1100;
    else           be = 4'b1111;
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic half, input logic byt, input logic [31:0] wd);
    logic [31:0] d;
    if (byt)       d = {4{wd[7:0]}};
    else if (half) d = {2{wd[15:0]}};
    else           d = wd;
    return d;
  endfunction

  // Lane 0 is the most significant byte on the bus (big-endian).
  function automatic logic [31:0] load_ext(input logic half, input logic byt, input logic sx,
                                           input logic [1:0] lo, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    case (lo)
      2'b00:   b = rd[31:24];
      2'b01:   b = rd[23:16];
      2'b10:   b = rd[15:8];
      default: b = rd[7:0];
    endcase
    h = lo[1] ? rd[15:0] : rd[31:16];
    if (byt)       v = {{24{sx & b[7]}}, b};
    else if (half) v = {{16{sx & h[15]}}, h};
    else           v = rd;
    return v;
  endfunction

  // Access legality and core-facing handshake, decoded straight from the request.
  always_comb begin
    acc_s       = MemRead | MemWrite;
    word_s      = ~MemHalf & ~MemByte;
    illegal_s   = (MemRead & MemWrite) | (MemHalf & MemByte) | (MemHalf & Addr[0])
                | (word_s & (Addr[1:0] != 2'b00));
    word_addr_s = Addr[31:2];
    Stall       = acc_s & ~illegal_s & (state_r != DONE);
    AddrErr     = acc_s & illegal_s & (state_r == IDLE);
  end

  // Bus sequencer; load shape is captured at issue so REQ never depends on core inputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      ld_rd_r   <= 1'b0;
      ld_half_r <= 1'b0;
      ld_byte_r <= 1'b0;
      ld_sext_r <= 1'b0;
      ld_lo_r   <= 2'b00;
      ReadData  <= 32'h0000_0000;
      BusErr    <= 1'b0;
      BusReq    <= 1'b0;
      BusWe     <= 1'b0;
      BusAddr   <= '0;
      BusBe     <= 4'b0000;
      BusWData  <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          BusErr <= 1'b0;
          if (acc_s && !illegal_s) begin
            state_r   <= REQ;
            cnt_r     <= '0;
            BusReq    <= 1'b1;
            BusWe     <= MemWrite;
            BusAddr   <= word_addr_s[BUS_AW-1:0];
            BusBe     <= lane_be(MemHalf, MemByte, Addr[1:0]);
            BusWData  <= lane_wdata(MemHalf, MemByte, WriteData);
            ld_rd_r   <= MemRead;
            ld_half_r <= MemHalf;
            ld_byte_r <= MemByte;
            ld_sext_r <= MemSignExtend;
            ld_lo_r   <= Addr[1:0];
          end
        end
        REQ: begin
          if (BusAck) begin
            if (ld_rd_r) ReadData <= load_ext(ld_half_r, ld_byte_r, ld_sext_r, ld_lo_r, BusRData);
            state_r <= DONE;
            BusReq  <= 1'b0;
            BusWe   <= 1'b0;
            BusBe   <= 4'b0000;
          end else if (cnt_r == CW'(TIMEOUT - 1)) begin
            ReadData <= 32'h0000_0000;
            BusErr   <= 1'b1;
            state_r  <= DONE;
            BusReq   <= 1'b0;
            BusWe    <= 1'b0;
            BusBe    <= 4'b0000;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          BusErr  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          BusReq  <= 1'b0;
          BusErr  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model sets the expected
// outputs each cycle and one negedge process compares them, plus literal pins.
module tb_load_store_unit;
  localparam int TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        RST, MemRead, MemWrite, MemHalf, MemByte, MemSignExtend, BusAck;
  logic [31:0] Addr, WriteData, BusRData;
  logic [31:0] ReadData, BusWData;
  logic        Stall, AddrErr, BusErr, BusReq, BusWe;
  logic [29:0] BusAddr;
  logic [3:0]  BusBe;

  int n_vec = 0;
  int n_err = 0;

  logic        chk = 1'b0;
  logic        e_stall, e_addrerr, e_buserr, e_busreq, e_we;
  logic [29:0] e_addr;
  logic [3:0]  e_be;
  logic [31:0] e_wd, e_rd;

  int          stall_cnt = 0, req_cnt = 0, aerr_cnt = 0, berr_cnt = 0;
  logic [29:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wd;
  logic        cap_we;

  always #5 CLK = ~CLK;

  load_store_unit #(.TIMEOUT(TIMEOUT), .BUS_AW(30)) dut (
    .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .MemHalf(MemHalf),
    .MemByte(MemByte), .MemSignExtend(MemSignExtend), .Addr(Addr), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .AddrErr(AddrErr), .BusErr(BusErr), .BusReq(BusReq),
    .BusWe(BusWe), .BusAddr(BusAddr), .BusBe(BusBe), .BusWData(BusWData),
    .BusRData(BusRData), .BusAck(BusAck));

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Spec-level models of the lane rules.
  function automatic logic [3:0] m_be(input logic half, input logic byt, input logic [31:0] a);
    int sh;
    sh = 3 - int'(a[1:0]);
    if (byt) return 4'(1 << sh);
    if (half) return a[1] ? 4'd3 : 4'd12;
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wd(input logic half, input logic byt, input logic [31:0] wd);
    if (byt) return (wd & 32'hFF) * 32'h0101_0101;
    if (half) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_ext(input logic half, input logic byt, input logic sx,
                                        input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int sh;
    if (byt) begin
      sh = 8 * (3 - int'(a[1:0]));
      v = (rd >> sh) & 32'hFF;
      if (sx && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (half) begin
      sh = 16 * (1 - int'(a[1]));
      v = (rd >> sh) & 32'hFFFF;
      if (sx && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Per-cycle comparison and event counters.
  always @(negedge CLK) begin
    if (chk) begin
      cmp("stall", {31'd0, Stall}, {31'd0, e_stall});
      cmp("addrerr", {31'd0, AddrErr}, {31'd0, e_addrerr});
      cmp("buserr", {31'd0, BusErr}, {31'd0, e_buserr});
      cmp("busreq", {31'd0, BusReq}, {31'd0, e_busreq});
      cmp("readdata", ReadData, e_rd);
      if (e_busreq) begin
        cmp("buswe", {31'd0, BusWe}, {31'd0, e_we});
        cmp("busaddr", {2'd0, BusAddr}, {2'd0, e_addr});
        cmp("busbe", {28'd0, BusBe}, {28'd0, e_be});
        cmp("buswdata", BusWData, e_wd);
      end
      if (Stall) stall_cnt++;
      if (AddrErr) aerr_cnt++;
      if (BusErr) berr_cnt++;
      if (BusReq) begin
        req_cnt++;
        cap_addr = BusAddr;
        cap_be   = BusBe;
        cap_wd   = BusWData;
        cap_we   = BusWe;
      end
    end
  end

  // One core access; dly = REQ cycles before ack (0 = first), >= TIMEOUT means none.
  task automatic access(input logic rd, input logic wr, input logic half, input logic byt,
                        input logic sx, input logic [31:0] a, input logic [31:0] wd,
                        input int dly, input logic [31:0] rdat);
    logic ill;
    MemRead = rd; MemWrite = wr; MemHalf = half; MemByte = byt; MemSignExtend = sx;
    Addr = a; WriteData = wd;
    ill = (rd & wr) | (half & byt) | (half & a[0]) | (!half && !byt && a[1:0] != 2'b00);
    e_buserr = 1'b0; e_busreq = 1'b0;
    if (ill) begin
      e_stall = 1'b0; e_addrerr = 1'b1;
      @(posedge CLK) #1;
      MemRead = 1'b0; MemWrite = 1'b0; e_addrerr = 1'b0;
    end else begin
      e_stall = 1'b1; e_addrerr = 1'b0;
      @(posedge CLK) #1;
      e_busreq = 1'b1; e_we = wr; e_addr = a[31:2];
      e_be = m_be(half, byt, a); e_wd = m_wd(half, byt, wd);
      for (int k = 0; k < TIMEOUT; k++) begin
        if (k == dly) begin BusAck = 1'b1; BusRData = rdat; end
        @(posedge CLK) #1;
        BusAck = 1'b0;
        if (k == dly) begin
          if (rd) e_rd = m_ext(half, byt, sx, a, rdat);
          break;
        end
        if (k == TIMEOUT - 1) begin e_rd = 32'd0; e_buserr = 1'b1; end
      end
      e_busreq = 1'b0; e_stall = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      @(posedge CLK) #1;
      e_buserr = 1'b0;
    end
  endtask

  initial begin
    int s0, r0, a0, b0;
    RST = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemHalf = 1'b0; MemByte = 1'b0;
    MemSignExtend = 1'b0; Addr = 32'd0; WriteData = 32'd0; BusRData = 32'd0; BusAck = 1'b0;
    e_stall = 1'b0; e_addrerr = 1'b0; e_buserr = 1'b0; e_busreq = 1'b0; e_we = 1'b0;
    e_addr = 30'd0; e_be = 4'd0; e_wd = 32'd0; e_rd = 32'd0;
    chk = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    cmp("reset_busaddr", {2'd0, BusAddr}, 32'd0);
    cmp("reset_buswdata", BusWData, 32'd0);

    s0 = stall_cnt;
    access(0, 1, 0, 0, 0, 32'h100, 32'hDEAD_BEEF, 0, 32'd0);
    cmp("sw_addr", {2'd0, cap_addr}, 32'h40);
    cmp("sw_be", {28'd0, cap_be}, 32'hF);
    cmp("sw_we", {31'd0, cap_we}, 32'd1);
    cmp("sw_stall_cycles", 32'(stall_cnt - s0), 32'd2);

    access(0, 1, 0, 1, 0, 32'h102, 32'h0000_00A5, 1, 32'd0);
    cmp("sb_be", {28'd0, cap_be}, 32'h2);
    cmp("sb_wd", cap_wd, 32'hA5A5_A5A5);
    access(0, 1, 1, 0, 0, 32'h102, 32'h0000_1234, 0, 32'd0);
    cmp("sh_be", {28'd0, cap_be}, 32'h3);

    access(1, 0, 0, 1, 1, 32'h103, 32'h1122_3380, 0, 32'h1122_3380);
    cmp("lb_signed", ReadData, 32'hFFFF_FF80);
    access(1, 0, 0, 1, 0, 32'h103, 32'h0, 2, 32'h1122_3380);
    cmp("lbu", ReadData, 32'h0000_0080);
    access(1, 0, 1, 0, 1, 32'h100, 32'h0, 0, 32'h8001_BEEF);
    cmp("lh_signed", ReadData, 32'hFFFF_8001);
    access(1, 0, 0, 1, 1, 32'h001, 32'h0, 0, 32'h11A2_3344);
    access(1, 0, 1, 0, 0, 32'h102, 32'h0, 1, 32'h1234_9ABC);
    cmp("lhu_hi", ReadData, 32'h0000_9ABC);
    access(0, 1, 0, 0, 0, 32'h104, 32'h5555_AAAA, 0, 32'hFFFF_FFFF);
    cmp("store_keeps_rd", ReadData, 32'h0000_9ABC);

    r0 = req_cnt; a0 = aerr_cnt; s0 = stall_cnt;
    access(1, 0, 1, 0, 1, 32'h101, 32'h0, 0, 32'd0);
    access(1, 0, 0, 0, 0, 32'h102, 32'h0, 0, 32'd0);
    access(1, 1, 0, 0, 0, 32'h100, 32'h0, 0, 32'd0);
    access(0, 1, 1, 1, 0, 32'h100, 32'h0, 0, 32'd0);
    cmp("illegal_aerr", 32'(aerr_cnt - a0), 32'd4);
    cmp("illegal_noreq", 32'(req_cnt - r0), 32'd0);
    cmp("illegal_nostall", 32'(stall_cnt - s0), 32'd0);

    s0 = stall_cnt;
    access(1, 0, 0, 0, 0, 32'h200, 32'h0, 4, 32'hCAFE_F00D);
    cmp("delayed_stall", 32'(stall_cnt - s0), 32'd6);
    cmp("lw_delayed", ReadData, 32'hCAFE_F00D);

    s0 = stall_cnt; b0 = berr_cnt;
    access(1, 0, 0, 0, 0, 32'h204, 32'h0, TIMEOUT, 32'd0);
    cmp("timeout_stall", 32'(stall_cnt - s0), 32'd17);
    cmp("timeout_buserr", 32'(berr_cnt - b0), 32'd1);
    cmp("timeout_rd", ReadData, 32'd0);

    access(1, 0, 0, 0, 0, 32'h208, 32'h0, 0, 32'h0BAD_F00D);
    BusAck = 1'b1; BusRData = 32'h7777_7777;
    @(posedge CLK) #1;
    BusAck = 1'b0;
    @(posedge CLK) #1;

    // Reset while a load is waiting in REQ; the late ack must be ignored.
    MemRead = 1'b1; MemWrite = 1'b0; MemHalf = 1'b0; MemByte = 1'b0; Addr = 32'h300;
    WriteData = 32'h0; e_stall = 1'b1;
    @(posedge CLK) #1;
    e_busreq = 1'b1; e_we = 1'b0; e_addr = 30'hC0; e_be = 4'hF; e_wd = 32'h0;
    RST = 1'b0;
    @(posedge CLK) #1;
    RST = 1'b1; MemRead = 1'b0; BusAck = 1'b1; BusRData = 32'hFFFF_FFFF;
    e_busreq = 1'b0; e_stall = 1'b0; e_rd = 32'd0;
    @(posedge CLK) #1;
    BusAck = 1'b0;
    @(posedge CLK) #1;
    cmp("post_reset_rd", ReadData, 32'd0);
    access(1, 0, 0, 0, 0, 32'h10, 32'h0, 0, 32'h1234_5678);
    cmp("post_reset_lw", ReadData, 32'h1234_5678);

    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
